// File: rtl/params_pkg.sv
// Shared types and defaults for the issue-stage scoreboard / hazard unit.
// Decode request layout, stall cause encoding and latency bounds live here.
package params_pkg;

  localparam int REGISTER_WIDTH = 5;
  localparam int MAX_LATENCY    = 8;
  // Wide enough to hold a latency of 16, the largest legal MAX_LATENCY.
  localparam int LAT_W          = 5;

  typedef struct packed {
    logic [REGISTER_WIDTH-1:0] rs1;
    logic [REGISTER_WIDTH-1:0] rs2;
    logic [REGISTER_WIDTH-1:0] rd;
    logic                      rs1_needed;
    logic                      rs2_needed;
    logic                      rd_wr_en;
    logic                      is_branch;
    logic                      is_mem;
    logic [LAT_W-1:0]          latency;
  } hazard_req_t;

  typedef enum logic [2:0] {
    CAUSE_NONE     = 3'd0,
    CAUSE_RAW      = 3'd1,
    CAUSE_WAW      = 3'd2,
    CAUSE_WB_PORT  = 3'd3,
    CAUSE_MEM_BUSY = 3'd4,
    CAUSE_BRANCH   = 3'd5
  } stall_cause_t;

endpackage

// File: rtl/wb_slot_reserve.sv
// Writeback-port reservation shift register: slot k set means the port is owned
// k cycles from now. Slots shift toward slot 0 every cycle.
module wb_slot_reserve
  import params_pkg::*;
#(
  parameter int MAX_LATENCY = params_pkg::MAX_LATENCY
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             reserve_en,
  input  logic [LAT_W-1:0] latency,
  output logic             slot_free,
  output logic             slot0_busy
);

  logic [MAX_LATENCY-1:0] slot_q;
  logic [MAX_LATENCY-1:0] slot_d;
  logic [MAX_LATENCY-1:0] lat_hit;
  logic [MAX_LATENCY-1:0] taken;

  // Slot L-1 after this cycle's shift is slot L of the current register.
  for (genvar gi = 0; gi < MAX_LATENCY; gi++) begin : g_slot
    assign lat_hit[gi] = (latency == LAT_W'(gi + 1));
    if (gi + 1 < MAX_LATENCY) begin : g_mid
      assign taken[gi] = slot_q[gi+1];
    end else begin : g_top
      assign taken[gi] = 1'b0;
    end
  end

  assign slot_free  = ~|(lat_hit & taken);
  assign slot0_busy = slot_q[0];

  always_comb begin
    slot_d = slot_q >> 1;
    if (reserve_en) begin
      slot_d = slot_d | lat_hit;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

endmodule

// File: rtl/scoreboard_hazard_unit.sv
// In-order issue scoreboard: RAW/WAW pending bits, writeback-port reservation,
// memory/branch interlocks. Optional stall perf counters under HAZARD_PERF_CNT_EN.
module scoreboard_hazard_unit
  import params_pkg::*;
#(
  parameter int REGISTER_WIDTH = params_pkg::REGISTER_WIDTH,
  parameter int MAX_LATENCY    = params_pkg::MAX_LATENCY,
  parameter int PERF_CNT_WIDTH = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      dec_valid_i,
  input  hazard_req_t               dec_hazard_i,
  input  logic                      wb_valid_i,
  input  logic [REGISTER_WIDTH-1:0] wb_rd_i,
  input  logic                      mem_busy_i,
  input  logic                      mem_done_i,
  output logic                      issue_o,
  output logic                      stall_decode_o,
  output logic                      stall_fetch_o,
  output logic                      mem_wb_stall_o,
  output stall_cause_t              stall_cause_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [PERF_CNT_WIDTH-1:0] perf_raw_o,
  output logic [PERF_CNT_WIDTH-1:0] perf_waw_o,
  output logic [PERF_CNT_WIDTH-1:0] perf_struct_o
`endif
);

  localparam int NUM_REGS = 2 ** REGISTER_WIDTH;
  localparam int CNT_W    = $clog2(MAX_LATENCY + 2);

  logic [NUM_REGS-1:0]       pend_q, pend_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [REGISTER_WIDTH-1:0] rs1_idx, rs2_idx, rd_idx;
  logic                      active;
  logic                      raw_hit, waw_hit, mem_hit, port_hit, br_hit;
  logic                      slot_free, slot0_busy, reserve_en, rd_write;

  assign rs1_idx = REGISTER_WIDTH'(dec_hazard_i.rs1);
  assign rs2_idx = REGISTER_WIDTH'(dec_hazard_i.rs2);
  assign rd_idx  = REGISTER_WIDTH'(dec_hazard_i.rd);

  // Gating with rst_ni keeps every output quiet while reset is held.
  assign active = rst_ni & dec_valid_i;

  assign raw_hit  = (dec_hazard_i.rs1_needed && rs1_idx != '0 && pend_q[rs1_idx]) ||
                    (dec_hazard_i.rs2_needed && rs2_idx != '0 && pend_q[rs2_idx]);
  assign waw_hit  = dec_hazard_i.rd_wr_en && rd_idx != '0 && pend_q[rd_idx];
  assign mem_hit  = dec_hazard_i.is_mem && mem_busy_i;
  assign port_hit = !dec_hazard_i.is_mem && !slot_free;
  assign br_hit   = dec_hazard_i.is_branch && (cnt_q != '0 || mem_busy_i);

  always_comb begin
    stall_cause_o = CAUSE_NONE;
    if (active) begin
      if (mem_hit)       stall_cause_o = CAUSE_MEM_BUSY;
      else if (raw_hit)  stall_cause_o = CAUSE_RAW;
      else if (waw_hit)  stall_cause_o = CAUSE_WAW;
      else if (port_hit) stall_cause_o = CAUSE_WB_PORT;
      else if (br_hit)   stall_cause_o = CAUSE_BRANCH;
    end
  end

  assign stall_decode_o = (stall_cause_o != CAUSE_NONE);
  assign stall_fetch_o  = stall_decode_o;
  assign issue_o        = active & ~stall_decode_o;
  assign mem_wb_stall_o = rst_ni & mem_done_i & slot0_busy;
  assign reserve_en     = issue_o & ~dec_hazard_i.is_mem;
  assign rd_write       = issue_o & dec_hazard_i.rd_wr_en;

  wb_slot_reserve #(
    .MAX_LATENCY(MAX_LATENCY)
  ) u_wb_slot_reserve (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .reserve_en(reserve_en),
    .latency   (dec_hazard_i.latency),
    .slot_free (slot_free),
    .slot0_busy(slot0_busy)
  );

  // Clear first so a same-cycle set of the same register wins.
  always_comb begin
    pend_d = pend_q;
    if (wb_valid_i) begin
      pend_d[wb_rd_i] = 1'b0;
    end
    if (rd_write && rd_idx != '0) begin
      pend_d[rd_idx] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (rd_write && !wb_valid_i && cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!rd_write && wb_valid_i && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [PERF_CNT_WIDTH-1:0] perf_raw_q, perf_waw_q, perf_struct_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_raw_q    <= '0;
      perf_waw_q    <= '0;
      perf_struct_q <= '0;
    end else begin
      if (stall_cause_o == CAUSE_RAW) perf_raw_q <= perf_raw_q + 1'b1;
      if (stall_cause_o == CAUSE_WAW) perf_waw_q <= perf_waw_q + 1'b1;
      if (stall_cause_o == CAUSE_WB_PORT || stall_cause_o == CAUSE_MEM_BUSY) begin
        perf_struct_q <= perf_struct_q + 1'b1;
      end
    end
  end

  assign perf_raw_o    = perf_raw_q;
  assign perf_waw_o    = perf_waw_q;
  assign perf_struct_o = perf_struct_q;
`endif

endmodule

// File: doc/scoreboard_hazard_unit.md
SCOREBOARD_HAZARD_UNIT -- requirements
Module: scoreboard_hazard_unit

Interface
REQ-001 SHALL have parameter REGISTER_WIDTH, default params_pkg::REGISTER_WIDTH, which sets the architectural register index width; NUM_REGS = 2**REGISTER_WIDTH.
REQ-002 SHALL have parameter MAX_LATENCY, default 8, which is the largest fixed execute latency in cycles; legal range 1..16.
REQ-003 SHALL have parameter PERF_CNT_WIDTH, default 32, which sets the width of the perf counters.
REQ-004 clk_i  input  1  single clock, rising edge.
REQ-005 rst_ni  input  1  asynchronous, active-low reset.
REQ-006 dec_valid_i  input  1  decode holds a valid instruction.
REQ-007 dec_hazard_i  input  hazard_req_t  fields: rs1, rs2, rd, rs1_needed, rs2_needed, rd_wr_en, is_branch, is_mem, latency (1..MAX_LATENCY; ignored when is_mem).
REQ-008 wb_valid_i  input  1  register-file write this cycle.
REQ-009 wb_rd_i  input  REGISTER_WIDTH  register being written back.
REQ-010 mem_busy_i  input  1  memory unit holds an outstanding access.
REQ-011 mem_done_i  input  1  memory result is ready for writeback this cycle.
REQ-012 issue_o  output  1  the decode instruction issues this cycle.
REQ-013 stall_decode_o  output  1  hold decode; stall_fetch_o  output  1  equals stall_decode_o.
REQ-014 mem_wb_stall_o  output  1  memory must hold its result; the writeback port is taken.
REQ-015 stall_cause_o  output  stall_cause_t  values NONE/RAW/WAW/WB_PORT/MEM_BUSY/BRANCH.

Function
REQ-016 SHALL keep a pending bit per register; register 0 is never pending.
REQ-017 On issue_o with rd_wr_en and rd!=0, pending[rd] SHALL be set at the next edge.
REQ-018 On wb_valid_i, pending[wb_rd_i] SHALL be cleared at the next edge; if a set of the same register happens in the same cycle, the set wins.
REQ-019 RAW: stall when a needed rs1/rs2 (!=0) is pending; registered state only, no same-cycle writeback bypass.
REQ-020 WAW: stall when rd_wr_en, rd!=0 and pending[rd].
REQ-021 SHALL keep an MAX_LATENCY-entry writeback reservation shift register; it shifts toward slot 0 every cycle.
REQ-022 A fixed-latency issue of latency L SHALL require slot L-1 (post-shift) to be free, and SHALL reserve that slot; if the slot is taken, stall with WB_PORT.
REQ-023 An is_mem instruction SHALL stall with MEM_BUSY while mem_busy_i is high; it reserves no slot.
REQ-024 mem_wb_stall_o SHALL equal mem_done_i AND slot 0 reserved; fixed-latency pipelines always own the port.
REQ-025 SHALL keep an outstanding-write counter (width clog2(MAX_LATENCY+2)), +1 per issue with rd_wr_en, -1 per wb_valid_i, net 0 when both happen; an is_branch instruction SHALL stall with BRANCH while the counter is nonzero or mem_busy_i is high.
REQ-026 Stall priority SHALL be MEM_BUSY > RAW > WAW > WB_PORT > BRANCH; stall_cause_o reports the highest active cause, and NONE when no stall is active.
REQ-027 issue_o = dec_valid_i AND NOT stall_decode_o; stall outputs are combinational, with zero-cycle latency from inputs.
REQ-028 With dec_valid_i low there SHALL be no stall and no state change except the shift and writeback clears.
REQ-029 A counter underflow (wb_valid_i at count 0) SHALL saturate at 0.

Reset
REQ-030 rst_ni low SHALL asynchronously clear pending bits, reservations, the counter and perf counters, at any time, including mid-operation.
REQ-031 During reset, issue_o=0, stall_decode_o=0, mem_wb_stall_o=0, stall_cause_o=NONE.

Configuration
REQ-032 With HAZARD_PERF_CNT_EN defined, SHALL add outputs perf_raw_o, perf_waw_o, perf_struct_o (WB_PORT+MEM_BUSY), each PERF_CNT_WIDTH bits, counting stall cycles per cause and wrapping at 2**PERF_CNT_WIDTH.
REQ-033 Without HAZARD_PERF_CNT_EN, those ports and counters SHALL be absent and the remaining behaviour SHALL be identical.

Structure
REQ-034 hazard_req_t, stall_cause_t and the MAX_LATENCY default SHALL live in params_pkg.
REQ-035 The reservation shift register SHALL be a sub-module, wb_slot_reserve, with inputs reserve_en and latency and outputs slot_free and slot0_busy.

Verification
REQ-036 Issue ADD rd=5 latency 3; next cycle decode rs1=5 -> RAW stall until wb_valid_i with wb_rd_i=5, then issue_o=1 the cycle after.
REQ-037 Issue latency 3, then next cycle latency 2 -> second stalls with WB_PORT for one cycle, then issues.
REQ-038 wb_valid_i wb_rd_i=7 in the same cycle as issue rd=7 -> pending[7]=1 afterwards.
REQ-039 mem_done_i=1 while slot 0 is reserved -> mem_wb_stall_o=1; the next cycle with slot 0 free -> 0.
REQ-040 Branch with counter=2 -> BRANCH stall until the counter reaches 0; assert rst_ni low mid-stall -> all state clear, stall_decode_o=0.
REQ-041 With HAZARD_PERF_CNT_EN, 4 RAW stall cycles -> perf_raw_o=4 and perf_waw_o=0.
